// File: rtl/iddmm_pkg.sv
// Shared IDDMM definitions: default word geometry and the result-select state type.
package iddmm_pkg;

    localparam int IDDMM_K = 128;
    localparam int IDDMM_N = 32;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } iddmm_rsel_state_t;

endpackage

// File: rtl/iddmm_word_buf.sv
// N x K result word buffer with its own write counter, full flag and async read port.
// Storage is deliberately left out of reset; only the counter is cleared.
module iddmm_word_buf #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [K-1:0]      wr_data,
    input  logic              clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [K-1:0]      rd_data,
    output logic              full,
    output logic [ADDR_W:0]   cnt
);

    logic [K-1:0] mem [N];
    logic         wr_ok;

    assign full  = (cnt == (ADDR_W+1)'(N));
    assign wr_ok = wr_en && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wr_ok) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[cnt[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/iddmm_result_sel.sv
// IDDMM output stage: buffers raw and subtracted results, picks one by final sign, drains LSW first.
// Optional sticky drop/error flag o_err under IDDMM_RESULT_SEL_ERR_CHK_EN.
module iddmm_result_sel
    import iddmm_pkg::*;
#(
    parameter int K      = IDDMM_K,
    parameter int N      = IDDMM_N,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr_a_en,
    input  logic [K-1:0] i_wr_a_data,
    input  logic         i_wr_sub_en,
    input  logic [K-1:0] i_wr_sub_data,
    input  logic         i_cal_done,
    input  logic         i_cal_sign,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [K-1:0] o_data,
    output logic         o_last,
    output logic         o_sel,
    output logic         o_busy
`ifdef IDDMM_RESULT_SEL_ERR_CHK_EN
    ,
    output logic         o_err
`endif
);

    iddmm_rsel_state_t state_q, state_d;

    logic              done_q;
    logic              sel_q;
    logic [ADDR_W-1:0] rd_ptr_q;

    logic              collect;
    logic              last_word;
    logic              xfer;
    logic              last_xfer;

    logic [K-1:0]      rd_a, rd_sub;
    logic              full_a, full_sub;
    logic [ADDR_W:0]   cnt_a, cnt_sub;

    assign collect   = (state_q == COLLECT);
    assign last_word = (rd_ptr_q == ADDR_W'(N-1));
    assign xfer      = (state_q == DRAIN) && i_ready;
    assign last_xfer = xfer && last_word;

    // Writes outside COLLECT never reach the buffers.
    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (i_wr_a_en && collect),
        .wr_data (i_wr_a_data),
        .clr     (last_xfer),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_a),
        .full    (full_a),
        .cnt     (cnt_a)
    );

    iddmm_word_buf #(.K(K), .N(N), .ADDR_W(ADDR_W)) u_buf_sub (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (i_wr_sub_en && collect),
        .wr_data (i_wr_sub_data),
        .clr     (last_xfer),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_sub),
        .full    (full_sub),
        .cnt     (cnt_sub)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Transition looks only at registered flags, so DRAIN starts one edge after they settle.
    always_comb begin
        state_d = state_q;
        o_valid = 1'b0;
        o_data  = '0;
        o_last  = 1'b0;
        case (state_q)
            COLLECT: begin
                if (done_q && full_a && full_sub) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                o_valid = 1'b1;
                o_data  = sel_q ? rd_sub : rd_a;
                o_last  = last_word;
                if (last_xfer) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q   <= 1'b0;
            sel_q    <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            if (last_xfer) begin
                done_q <= 1'b0;
            end else if (collect && i_cal_done) begin
                done_q <= 1'b1;
            end
            // A repeated done in COLLECT simply overwrites the latched sign.
            if (collect && i_cal_done) begin
                sel_q <= i_cal_sign;
            end
            if (last_xfer) begin
                rd_ptr_q <= '0;
            end else if (xfer) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign o_sel  = sel_q;
    assign o_busy = (state_q == DRAIN) || done_q || (cnt_a != '0) || (cnt_sub != '0);

`ifdef IDDMM_RESULT_SEL_ERR_CHK_EN
    logic err_q;
    logic err_set;

    assign err_set = (i_wr_a_en   && (!collect || full_a))
                  || (i_wr_sub_en && (!collect || full_sub))
                  || (i_cal_done  && (!collect || done_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`endif

endmodule

// File: tb/tb_iddmm_result_sel.sv
// Self-checking bench for iddmm_result_sel (K=8, N=4) against a queue-based result model.
module tb_iddmm_result_sel;

    localparam int K = 8;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_wr_a_en, i_wr_sub_en, i_cal_done, i_cal_sign, i_ready;
    logic [K-1:0] i_wr_a_data, i_wr_sub_data;
    logic         o_valid, o_last, o_sel, o_busy;
    logic [K-1:0] o_data;
`ifdef IDDMM_RESULT_SEL_ERR_CHK_EN
    logic         o_err;
`endif

    iddmm_result_sel #(.K(K), .N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr_a_en     (i_wr_a_en),
        .i_wr_a_data   (i_wr_a_data),
        .i_wr_sub_en   (i_wr_sub_en),
        .i_wr_sub_data (i_wr_sub_data),
        .i_cal_done    (i_cal_done),
        .i_cal_sign    (i_cal_sign),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_data        (o_data),
        .o_last        (o_last),
        .o_sel         (o_sel),
        .o_busy        (o_busy)
`ifdef IDDMM_RESULT_SEL_ERR_CHK_EN
        ,
        .o_err         (o_err)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: what each buffer has accepted, whether done was seen, latched sign, sticky error.
    logic [K-1:0] m_a[$];
    logic [K-1:0] m_sub[$];
    bit           m_done;
    bit           m_sel;
    bit           m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_wr_a_en = 0; i_wr_sub_en = 0; i_cal_done = 0; i_cal_sign = 0;
        i_wr_a_data = '0; i_wr_sub_data = '0; i_ready = 0;
    endtask

    task automatic chk_err();
`ifdef IDDMM_RESULT_SEL_ERR_CHK_EN
        chk("err_flag", o_err, m_err);
`endif
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_n = 0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_sel", o_sel, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        m_a.delete(); m_sub.delete();
        m_done = 0; m_sel = 0; m_err = 0;
        chk_err();
        @(posedge clk);
        #2;
        rst_n = 1;
        tick();
    endtask

    // One COLLECT cycle: check idle outputs, drive the requested strobes, update the model.
    task automatic step(input bit a_en, input logic [K-1:0] a_d, input bit s_en,
                        input logic [K-1:0] s_d, input bit done, input bit sign);
        chk("collect_valid", o_valid, 0);
        chk("collect_data", o_data, 0);
        chk("collect_busy", o_busy, m_done || m_a.size() != 0 || m_sub.size() != 0);
        i_wr_a_en = a_en; i_wr_a_data = a_d;
        i_wr_sub_en = s_en; i_wr_sub_data = s_d;
        i_cal_done = done; i_cal_sign = sign;
        if (a_en) begin
            if (m_a.size() < N) m_a.push_back(a_d); else m_err = 1;
        end
        if (s_en) begin
            if (m_sub.size() < N) m_sub.push_back(s_d); else m_err = 1;
        end
        if (done) begin
            if (m_done) m_err = 1;
            m_done = 1;
            m_sel = sign;
        end
        tick();
        idle_inputs();
    endtask

    function automatic bit model_complete();
        return m_done && m_a.size() == N && m_sub.size() == N;
    endfunction

    // Called right after the edge where done and both full flags are registered.
    task automatic enter_drain();
        chk("pre_drain_valid", o_valid, 0);
        chk("pre_drain_busy", o_busy, 1);
        tick();
        chk("drain_start_valid", o_valid, 1);
    endtask

    // stall: 0 none, 1 random, 2 hold word 1 for 3 cycles. abort_at: reset once that many words are accepted.
    task automatic drain(input int stall, input bit inject, input int abort_at);
        logic [K-1:0] exp_q[$];
        int idx = 0;
        int cyc = 0;
        int held = 0;
        if (m_sel) exp_q = m_sub; else exp_q = m_a;
        while (idx < N && cyc < 200) begin
            chk("drain_valid", o_valid, 1);
            chk("drain_data", o_data, exp_q[idx]);
            chk("drain_last", o_last, idx == N - 1);
            chk("drain_sel", o_sel, m_sel);
            chk("drain_busy", o_busy, 1);
            if (idx == abort_at) begin
                reset_dut();
                return;
            end
            case (stall)
                1: i_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    i_ready = !(idx == 1 && held < 3);
                    if (idx == 1) held++;
                end
                default: i_ready = 1;
            endcase
            if (inject) begin
                i_wr_sub_en = 1; i_wr_sub_data = K'($urandom);
                i_wr_a_en = 1'($urandom); i_wr_a_data = K'($urandom);
                i_cal_done = 1'($urandom); i_cal_sign = 1'($urandom);
                m_err = 1;
            end
            tick();
            if (i_ready) idx++;
            cyc++;
            idle_inputs();
        end
        chk("drain_words", idx, N);
        if (stall == 0) chk("drain_cycles", cyc, N);
        if (stall == 2) chk("stall_cycles", cyc, N + 3);
        chk("post_valid", o_valid, 0);
        chk("post_last", o_last, 0);
        chk("post_data", o_data, 0);
        chk("post_busy", o_busy, 0);
        chk("post_sel", o_sel, m_sel);
        chk_err();
        m_a.delete(); m_sub.delete();
        m_done = 0;
    endtask

    task automatic random_collect(input bit overflow, input bit dup_done);
        int guard = 0;
        bit a_en, s_en, d_en, extra_done;
        extra_done = dup_done;
        while (!model_complete() && guard < 200) begin
            a_en = $urandom_range(0, 1) && (m_a.size() < N || overflow);
            s_en = $urandom_range(0, 1) && (m_sub.size() < N || overflow);
            d_en = ($urandom_range(0, 3) == 0) && (!m_done || extra_done);
            if (d_en && m_done) extra_done = 0;
            step(a_en, K'($urandom), s_en, K'($urandom), d_en, 1'($urandom));
            guard++;
        end
        chk("collect_complete", model_complete(), 1);
    endtask

    logic [K-1:0] va[4];
    logic [K-1:0] vs[4];

    initial begin
        idle_inputs();
        #2;
        reset_dut();
        va = '{8'h11, 8'h22, 8'h33, 8'h44};
        vs = '{8'h01, 8'h02, 8'h03, 8'h04};

        // Basic raw select.
        for (int i = 0; i < N; i++) step(1, va[i], 1, vs[i], 0, 0);
        step(0, 0, 0, 0, 1, 0);
        enter_drain();
        drain(0, 0, -1);

        // Sub select with done arriving before the final sub write.
        for (int i = 0; i < N; i++) step(1, va[i], i < 3, vs[i], i == 2, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, vs[3], 0, 0);
        enter_drain();
        drain(0, 0, -1);

        // Backpressure on word 1.
        for (int i = 0; i < N; i++) step(1, va[i] + 8'h50, 1, vs[i] + 8'h70, i == N - 1, 0);
        enter_drain();
        drain(2, 0, -1);

        // Overflow in COLLECT, then strobes during DRAIN.
        for (int i = 0; i < N; i++) step(1, va[i], 1, vs[i], 0, 0);
        step(1, 8'hEE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        enter_drain();
        drain(0, 1, -1);

        // Reset after two words are accepted, then a clean op.
        for (int i = 0; i < N; i++) step(1, va[i], 1, vs[i], i == 0, 1);
        enter_drain();
        drain(0, 0, 2);
        for (int i = 0; i < N; i++) step(1, vs[i] + 8'h90, 1, va[i] + 8'h09, i == N - 1, 0);
        enter_drain();
        drain(0, 0, -1);

        // Randomised back-to-back ops.
        for (int op = 0; op < 16; op++) begin
            random_collect(op % 4 == 1, op % 5 == 2);
            enter_drain();
            drain(op % 3 == 0 ? 0 : 1, op % 6 == 5, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
